// File: rtl/mm3x3_seq_ctrl_pkg.sv
// Shared constants, state encoding and index helpers for the 3x3 sequential
// matrix-multiply controller.
package mm_pkg;

  localparam int DIM   = 3;
  localparam int W     = 18;
  localparam int NELEM = DIM * DIM;
  localparam int B_OFF = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic logic [3:0] rm_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(int'(r) * DIM + int'(c));
  endfunction

endpackage

// File: rtl/mm3x3_seq_ctrl_mac.sv
// W-bit unsigned multiply-accumulate, truncating modulo 2^W.
// acc presents the running sum including this cycle's product, so the
// controller can capture a finished dot product on the same edge that clears.
module mm_mac
  import mm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] acc
);

  logic [W-1:0]   acc_q;
  logic [2*W-1:0] prod;

  assign prod = a * b;
  assign acc  = acc_q + prod[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (clr)
      acc_q <= '0;
    else if (en)
      acc_q <= acc;
  end

endmodule

// File: rtl/mm3x3_seq_ctrl.sv
// Sequential 3x3 unsigned matrix multiply: serial load of A then B, 27 MAC
// cycles through one shared mm_mac, then a valid/ready drain of C row-major.
//
// state   | meaning
// IDLE    | waiting for A11, in_ready=1
// LOAD    | accepting A12..B33, in_ready=1
// COMPUTE | 27 MAC cycles over (i,j,k), no input accepted
// DRAIN   | presenting C11..C33 to the consumer
module mm3x3_seq_ctrl
  import mm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam logic [1:0] LAST_DIM  = 2'(DIM - 1);
  localparam logic [4:0] LOAD_LAST = 5'(2 * NELEM - 1);
  localparam logic [3:0] OUT_LAST  = 4'(NELEM - 1);

  state_t       state, state_nxt;
  logic [4:0]   load_idx;
  logic [1:0]   ci, cj, ck;
  logic [3:0]   out_idx;
  logic [W-1:0] a_mem [NELEM];
  logic [W-1:0] b_mem [NELEM];
  logic [W-1:0] c_mem [NELEM];

  logic         in_hs, out_hs, last_mac, mac_clr, mac_en;
  logic [W-1:0] mac_a, mac_b, mac_acc;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_mac  = (state == COMPUTE) && (ci == LAST_DIM) && (cj == LAST_DIM) && (ck == LAST_DIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = LOAD;
      LOAD:    if (in_hs && load_idx == LOAD_LAST) state_nxt = COMPUTE;
      COMPUTE: if (last_mac) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_idx == OUT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx <= '0;
      ci       <= '0;
      cj       <= '0;
      ck       <= '0;
      out_idx  <= '0;
    end else begin
      if (in_hs)
        load_idx <= (load_idx == LOAD_LAST) ? 5'd0 : load_idx + 5'd1;

      if (state == COMPUTE) begin
        if (ck == LAST_DIM) begin
          ck <= '0;
          if (cj == LAST_DIM) begin
            cj <= '0;
            ci <= (ci == LAST_DIM) ? 2'd0 : ci + 2'd1;
          end else begin
            cj <= cj + 2'd1;
          end
        end else begin
          ck <= ck + 2'd1;
        end
      end else begin
        ci <= '0;
        cj <= '0;
        ck <= '0;
      end

      if (out_hs)
        out_idx <= (out_idx == OUT_LAST) ? 4'd0 : out_idx + 4'd1;
    end
  end

  // A/B are written only on accepted handshakes; C at the close of each dot product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NELEM; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      if (in_hs) begin
        if (load_idx < 5'(B_OFF))
          a_mem[load_idx[3:0]] <= in_data;
        else
          b_mem[4'(load_idx - 5'(B_OFF))] <= in_data;
      end
      if (state == COMPUTE && ck == LAST_DIM)
        c_mem[rm_idx(ci, cj)] <= mac_acc;
    end
  end

  // out_data/out_last are preloaded so they stay independent of out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_last <= 1'b0;
    end else if (last_mac) begin
      out_data <= c_mem[0];
      out_last <= 1'b0;
    end else if (out_hs) begin
      if (out_idx == OUT_LAST) begin
        out_data <= '0;
        out_last <= 1'b0;
      end else begin
        out_data <= c_mem[4'(out_idx + 4'd1)];
        out_last <= (4'(out_idx + 4'd1) == OUT_LAST);
      end
    end
  end

  assign mac_a   = a_mem[rm_idx(ci, ck)];
  assign mac_b   = b_mem[rm_idx(ck, cj)];
  assign mac_en  = (state == COMPUTE);
  assign mac_clr = (state != COMPUTE) || (ck == LAST_DIM);

  mm_mac u_mac (
    .clk (clk),
    .rst (rst),
    .a   (mac_a),
    .b   (mac_b),
    .clr (mac_clr),
    .en  (mac_en),
    .acc (mac_acc)
  );

endmodule

// File: tb/tb_mm3x3_seq_ctrl.sv
// Directed bench for mm3x3_seq_ctrl: a table of matrix pairs with expected C,
// plus hand-written reset-abort sequences.
module tb_mm3x3_seq_ctrl;
  import mm_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] in_data, out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mm3x3_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic [8:0][W-1:0] a;
    logic [8:0][W-1:0] b;
    logic [8:0][W-1:0] c;
    bit                gaps;
    bit                stall;
    bit                garb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input vec_t v);
    int gap;
    for (int e = 0; e < 18; e++) begin
      gap = v.gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        step();
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = (e < 9) ? v.a[e] : v.b[e - 9];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_and_drain(input vec_t v);
    int         n, idx, hs, p;
    logic       hsnow;
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1001;
    n = 0;
    while (!out_valid && n < 40) begin
      if (v.garb) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        chk("in_ready_compute", in_ready, 0);
      end
      chk("busy_compute", busy, 1);
      step();
      n++;
    end
    chk("latency", n, 27);
    idx = 0;
    hs  = 0;
    p   = 0;
    while (hs < 9 && n < 200) begin
      out_ready = v.stall ? rdy_pat[p % 4] : 1'b1;
      p++;
      if (v.garb) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        chk("in_ready_drain", in_ready, 0);
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, v.c[idx]);
      chk("out_last", out_last, (idx == 8) ? 1 : 0);
      hsnow = out_valid && out_ready;
      step();
      n++;
      if (hsnow) begin
        idx++;
        hs++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("handshakes", hs, 9);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("out_data_after", out_data, 0);
    chk("out_last_after", out_last, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset(input string tag);
    #1 rst = 1'b1;
    #1 check_reset_outputs(tag);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    int c0 [9];
    c0 = '{18, 21, 24, 54, 66, 78, 90, 111, 132};
    for (int e = 0; e < 9; e++) begin
      vecs[0].a[e] = W'(e);
      vecs[0].b[e] = W'(e + 1);
      vecs[0].c[e] = W'(c0[e]);
      vecs[1].a[e] = 18'h3FFFF;
      vecs[1].b[e] = 18'h3FFFF;
      vecs[1].c[e] = W'(3);
      vecs[4].a[e] = (e % 4 == 0) ? W'(1) : W'(0);
      vecs[4].b[e] = W'(e + 1);
      vecs[4].c[e] = W'(e + 1);
      vecs[5].a[e] = W'(e + 1);
      vecs[5].b[e] = '0;
      vecs[5].c[e] = '0;
    end
    vecs[0].gaps = 0; vecs[0].stall = 0; vecs[0].garb = 0;
    vecs[1].gaps = 0; vecs[1].stall = 0; vecs[1].garb = 0;
    vecs[2] = vecs[0];
    vecs[2].gaps = 1; vecs[2].stall = 1;
    vecs[3] = vecs[0];
    vecs[3].garb = 1;
    vecs[4].gaps = 0; vecs[4].stall = 0; vecs[4].garb = 0;
    vecs[5].gaps = 0; vecs[5].stall = 0; vecs[5].garb = 0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // table run; entries 4 and 5 also exercise back-to-back pairs
    for (int v = 0; v < 6; v++) begin
      load_pair(vecs[v]);
      wait_and_drain(vecs[v]);
    end

    // abort after 10 loaded elements
    for (int e = 0; e < 10; e++) begin
      in_valid = 1'b1;
      in_data  = 18'h3FFFF;
      step();
    end
    in_valid = 1'b0;
    chk("busy_partial_load", busy, 1);
    pulse_reset("rst_load");
    load_pair(vecs[0]);
    wait_and_drain(vecs[0]);

    // abort mid-COMPUTE
    load_pair(vecs[1]);
    repeat (10) step();
    chk("busy_mid_compute", busy, 1);
    pulse_reset("rst_compute");
    load_pair(vecs[0]);
    wait_and_drain(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
